// File: rtl/sr_flip_flop_pkg.sv
// Shared definitions for the SR flip-flop lane: conflict-mode encoding and
// the per-bit next-state function used by every storage cell.
package sr_pkg;

  // Response of a bit to the simultaneous S=R=1 request
  typedef enum logic [1:0] {
    SR_HOLD      = 2'd0,
    SR_RESET_DOM = 2'd1,
    SR_SET_DOM   = 2'd2,
    SR_TOGGLE    = 2'd3
  } sr_mode_e;

  localparam int SR_MODE_MIN = 0;
  localparam int SR_MODE_MAX = 3;

  // Next state of a single SR bit given its current value and requests.
  // The conflict case always resolves to a known value so no X can arise.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_mode_e mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b10:   nxt = 1'b1;
      2'b01:   nxt = 1'b0;
      2'b11: begin
        case (mode)
          SR_HOLD:      nxt = q;
          SR_RESET_DOM: nxt = 1'b0;
          SR_SET_DOM:   nxt = 1'b1;
          SR_TOGGLE:    nxt = ~q;
          default:      nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_flip_flop_if.sv
// Bundle of set/reset requests and complementary stored-state outputs.
// The master side issues requests, the slave side (the flip-flop lane)
// returns Q and Qbar.
interface sr_flip_flop_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;

  modport master (
    output S,
    output R,
    input  Q,
    input  Qbar
  );

  modport slave (
    input  S,
    input  R,
    output Q,
    output Qbar
  );

endinterface

// File: rtl/sr_flip_flop_ff_bit.sv
// Single SR storage bit: one asynchronously cleared register whose next
// value comes from the shared sr_next function.
module sr_ff_bit
  import sr_pkg::*;
#(
  parameter sr_mode_e MODE = SR_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);

  // Register the next state; an active-low rst clears the bit immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      q <= sr_next(q, s, r, MODE);
    end
  end

endmodule

// File: rtl/sr_flip_flop.sv
// Lane of WIDTH independent clocked SR bits with complementary outputs.
// Each bit is its own sr_ff_bit cell; Qbar is derived combinationally from
// the registered Q, so S/R never reach the outputs without a clock edge.
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int BOTH_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  sr_flip_flop_if.slave  bus
);

  // Reject configurations that have no defined behaviour
  if (WIDTH < 1) begin : g_bad_width
    $error("sr_flip_flop: WIDTH must be at least 1");
  end
  if (BOTH_MODE < SR_MODE_MIN || BOTH_MODE > SR_MODE_MAX) begin : g_bad_mode
    $error("sr_flip_flop: BOTH_MODE must be in the range 0..3");
  end

  localparam sr_mode_e MODE = sr_mode_e'(BOTH_MODE[1:0]);

  logic [WIDTH-1:0] q_int;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_ff_bit #(
      .MODE (MODE)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .s   (bus.S[i]),
      .r   (bus.R[i]),
      .q   (q_int[i])
    );
  end

  assign bus.Q    = q_int;
  assign bus.Qbar = ~q_int;

  // Outputs stay complementary whenever the lane is out of reset
  a_qbar_complement : assert property (
    @(posedge clk) disable iff (!rst) (bus.Qbar == ~bus.Q)
  );

  // The stored state is cleared whenever reset is held
  a_reset_clears : assert property (
    @(posedge clk) !rst |-> (bus.Q == '0)
  );

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed bench for sr_flip_flop: four single-bit lanes (one per conflict
// mode) and one 4-bit lane share clock, reset and stimulus so every vector
// exercises all configurations at once.
module tb_sr_flip_flop;

  logic clk;
  logic rst;

  int checkCount;
  int failCount;

  sr_flip_flop_if #(.WIDTH(1)) if_hold ();
  sr_flip_flop_if #(.WIDTH(1)) if_rdom ();
  sr_flip_flop_if #(.WIDTH(1)) if_sdom ();
  sr_flip_flop_if #(.WIDTH(1)) if_tog  ();
  sr_flip_flop_if #(.WIDTH(4)) if_wide ();

  sr_flip_flop #(.WIDTH(1), .BOTH_MODE(0)) dut_hold (.clk(clk), .rst(rst), .bus(if_hold));
  sr_flip_flop #(.WIDTH(1), .BOTH_MODE(1)) dut_rdom (.clk(clk), .rst(rst), .bus(if_rdom));
  sr_flip_flop #(.WIDTH(1), .BOTH_MODE(2)) dut_sdom (.clk(clk), .rst(rst), .bus(if_sdom));
  sr_flip_flop #(.WIDTH(1), .BOTH_MODE(3)) dut_tog  (.clk(clk), .rst(rst), .bus(if_tog));
  sr_flip_flop #(.WIDTH(4), .BOTH_MODE(0)) dut_wide (.clk(clk), .rst(rst), .bus(if_wide));

  // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts the check and reports a mismatch
  task automatic checkOutput(input string tag, input logic [3:0] actual,
                             input logic [3:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  // Compare Q and Qbar of every lane against hand-computed expectations
  task automatic checkStep(input string tag, input logic eHold, input logic eRdom,
                           input logic eSdom, input logic eTog, input logic [3:0] eWide);
    checkOutput({tag, "/hold.Q"},    {3'b000, if_hold.Q},    {3'b000, eHold});
    checkOutput({tag, "/hold.Qbar"}, {3'b000, if_hold.Qbar}, {3'b000, ~eHold});
    checkOutput({tag, "/rdom.Q"},    {3'b000, if_rdom.Q},    {3'b000, eRdom});
    checkOutput({tag, "/rdom.Qbar"}, {3'b000, if_rdom.Qbar}, {3'b000, ~eRdom});
    checkOutput({tag, "/sdom.Q"},    {3'b000, if_sdom.Q},    {3'b000, eSdom});
    checkOutput({tag, "/sdom.Qbar"}, {3'b000, if_sdom.Qbar}, {3'b000, ~eSdom});
    checkOutput({tag, "/tog.Q"},     {3'b000, if_tog.Q},     {3'b000, eTog});
    checkOutput({tag, "/tog.Qbar"},  {3'b000, if_tog.Qbar},  {3'b000, ~eTog});
    checkOutput({tag, "/wide.Q"},    if_wide.Q,              eWide);
    checkOutput({tag, "/wide.Qbar"}, if_wide.Qbar,           ~eWide);
  endtask

  // Drive S/R/rst on the falling edge, then sample 1 ns after the next rising edge.
  // Single-bit lanes receive bit 0 of the vectors.
  task automatic applyStimulus(input logic [3:0] sVal, input logic [3:0] rVal,
                               input logic rstVal);
    @(negedge clk);
    rst       = rstVal;
    if_hold.S = sVal[0];  if_hold.R = rVal[0];
    if_rdom.S = sVal[0];  if_rdom.R = rVal[0];
    if_sdom.S = sVal[0];  if_sdom.R = rVal[0];
    if_tog.S  = sVal[0];  if_tog.R  = rVal[0];
    if_wide.S = sVal;     if_wide.R = rVal;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b0;
    if_hold.S = 1'b1;  if_hold.R = 1'b0;
    if_rdom.S = 1'b1;  if_rdom.R = 1'b0;
    if_sdom.S = 1'b1;  if_sdom.R = 1'b0;
    if_tog.S  = 1'b1;  if_tog.R  = 1'b0;
    if_wide.S = 4'b1111;  if_wide.R = 4'b0000;

    #1;
    checkStep("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    applyStimulus(4'b1111, 4'b0000, 1'b0);
    checkStep("reset_hold1", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    checkStep("reset_hold2", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkStep("release_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkStep("set", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001);
    applyStimulus(4'b0000, 4'b0001, 1'b1);
    checkStep("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkStep("hold0", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkStep("set_again", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001);
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    checkStep("conflict_from1", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkStep("idle_after_conflict", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    checkStep("conflict_second", 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001);

    applyStimulus(4'b0000, 4'b0001, 1'b1);
    checkStep("clear", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    checkStep("conflict_from0", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkStep("idle_from0", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);

    applyStimulus(4'b1010, 4'b0101, 1'b1);
    checkStep("wide_pattern1", 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010);
    applyStimulus(4'b0001, 4'b1000, 1'b1);
    checkStep("wide_pattern2", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0011);
    applyStimulus(4'b1111, 4'b0110, 1'b1);
    checkStep("wide_conflict", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011);

    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkStep("async_midcycle", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    checkStep("reset_ignores_sr", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkStep("set_after_release", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
